// File: rtl/pe_traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pe_traffic_gen
//  Brief    : NoC processing-element traffic endpoint. Injects timestamped
//             packets with a selectable destination pattern and Bernoulli rate,
//             and sinks packets while accumulating latency statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_traffic_gen #(
   parameter int          Address      = 0,
   parameter int          AddressWidth = 4,
   parameter int          NumPE        = 16,
   parameter int          DataWidth    = 32,
   parameter int          TotalWidth   = AddressWidth + DataWidth,
   parameter int          CntWidth     = 16,
   parameter logic [15:0] LfsrSeed     = 16'hACE1 ^ 16'(Address)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_enable,
   input  logic [2:0]                    i_pattern,
   input  logic [8:0]                    i_rate,
   input  logic [CntWidth-1:0]           i_pkt_limit,
   input  logic [TotalWidth-1:0]         i_data,
   input  logic                          i_data_valid,
   output logic                          o_data_ready,
   output logic [TotalWidth-1:0]         o_data,
   output logic                          o_data_valid,
   input  logic                          i_data_ready,
   output logic [CntWidth-1:0]           o_sent_cnt,
   output logic [CntWidth-1:0]           o_recv_cnt,
   output logic [DataWidth+CntWidth-1:0] o_lat_sum,
   output logic [DataWidth-1:0]          o_lat_max,
   output logic                          o_done
);

   localparam int                      c_sum_w   = DataWidth + CntWidth;
   localparam logic [AddressWidth-1:0] c_addr    = AddressWidth'(Address);
   localparam logic [AddressWidth-1:0] c_tornado = AddressWidth'((Address + (NumPE + 1) / 2) % NumPE);
   localparam logic [AddressWidth-1:0] c_neigh   = AddressWidth'((Address + 1) % NumPE);
   localparam logic [15:0]             c_taps    = 16'hB400;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GEN  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [DataWidth-1:0]    r_ts;
   logic [15:0]             r_lfsr;
   logic [TotalWidth-1:0]   r_data;
   logic                    r_valid;
   logic [CntWidth-1:0]     r_sent_cnt;
   logic                    r_done;
   logic [CntWidth-1:0]     r_recv_cnt;
   logic [c_sum_w-1:0]      r_lat_sum;
   logic [DataWidth-1:0]    r_lat_max;

   logic                    w_start;
   logic                    w_load;
   logic                    w_accept;
   logic                    w_finish;
   logic                    w_fire;
   logic [CntWidth-1:0]     w_sent_inc;
   logic                    w_limit_hit;
   logic [AddressWidth-1:0] w_dest;
   logic [AddressWidth-1:0] w_dest_rev;
   logic [AddressWidth-1:0] w_dest_rot;
   logic [AddressWidth-1:0] w_dest_trn;
   logic [DataWidth-1:0]    w_latency;
   logic [CntWidth-1:0]     w_recv_base;
   logic [c_sum_w-1:0]      w_sum_base;
   logic [DataWidth-1:0]    w_max_base;
   logic [CntWidth-1:0]     w_recv_nxt;
   logic [c_sum_w:0]        w_sum_ext;
   logic [c_sum_w-1:0]      w_sum_nxt;
   logic [DataWidth-1:0]    w_max_nxt;
   logic                    w_unused_rx_dest;

   // Bit permutations of the fixed node address
   for (genvar j = 0; j < AddressWidth; j++) begin : g_perm
      assign w_dest_rev[j] = c_addr[AddressWidth-1-j];
      assign w_dest_rot[j] = c_addr[(j + 1) % AddressWidth];
      assign w_dest_trn[j] = c_addr[(j + AddressWidth / 2) % AddressWidth];
   end

   always_comb begin
      w_dest = c_neigh;
      case (i_pattern)
         3'd0:    w_dest = r_lfsr[AddressWidth-1:0];
         3'd1:    w_dest = ~c_addr;
         3'd2:    w_dest = w_dest_rev;
         3'd3:    w_dest = w_dest_rot;
         3'd4:    w_dest = w_dest_trn;
         3'd5:    w_dest = c_tornado;
         default: w_dest = c_neigh;
      endcase
   end

   assign w_fire      = {1'b0, r_lfsr[7:0]} < i_rate;
   assign w_sent_inc  = r_sent_cnt + 1'b1;
   assign w_limit_hit = (i_pkt_limit != '0) && (w_sent_inc == i_pkt_limit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_load      = 1'b0;
      w_accept    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_enable) begin
               w_start     = 1'b1;
               w_state_nxt = S_GEN;
            end
         end
         S_GEN: begin
            if (!i_enable) begin
               w_state_nxt = S_IDLE;
            end else if (w_fire) begin
               w_load      = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // The enable request is only honoured once the flit is accepted
            if (i_data_ready) begin
               w_accept = 1'b1;
               if (w_limit_hit) begin
                  w_finish    = 1'b1;
                  w_state_nxt = S_DONE;
               end else if (!i_enable) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_GEN;
               end
            end
         end
         S_DONE: begin
            if (!i_enable) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ts       <= '0;
         r_lfsr     <= LfsrSeed;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_sent_cnt <= '0;
         r_done     <= 1'b0;
      end else begin
         r_ts <= r_ts + 1'b1;
         if (r_state == S_GEN) begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_taps : 16'h0000);
         end
         if (w_load) begin
            r_data  <= {w_dest, r_ts};
            r_valid <= 1'b1;
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
         if (w_start)       r_sent_cnt <= '0;
         else if (w_accept) r_sent_cnt <= w_sent_inc;
         if (w_start)       r_done <= 1'b0;
         else if (w_finish) r_done <= 1'b1;
      end
   end

   // Sink: a receive on the start edge counts against freshly cleared stats
   assign w_latency        = r_ts - i_data[DataWidth-1:0];
   assign w_unused_rx_dest = ^i_data[TotalWidth-1:DataWidth];

   always_comb begin
      w_recv_base = w_start ? '0 : r_recv_cnt;
      w_sum_base  = w_start ? '0 : r_lat_sum;
      w_max_base  = w_start ? '0 : r_lat_max;
      w_recv_nxt  = (&w_recv_base) ? w_recv_base : w_recv_base + 1'b1;
      w_sum_ext   = {1'b0, w_sum_base} + {{(CntWidth + 1){1'b0}}, w_latency};
      w_sum_nxt   = w_sum_ext[c_sum_w] ? {c_sum_w{1'b1}} : w_sum_ext[c_sum_w-1:0];
      w_max_nxt   = (w_latency > w_max_base) ? w_latency : w_max_base;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_recv_cnt <= '0;
         r_lat_sum  <= '0;
         r_lat_max  <= '0;
      end else if (i_data_valid) begin
         r_recv_cnt <= w_recv_nxt;
         r_lat_sum  <= w_sum_nxt;
         r_lat_max  <= w_max_nxt;
      end else if (w_start) begin
         r_recv_cnt <= '0;
         r_lat_sum  <= '0;
         r_lat_max  <= '0;
      end
   end

   assign o_data_ready = 1'b1;
   assign o_data       = r_data;
   assign o_data_valid = r_valid;
   assign o_sent_cnt   = r_sent_cnt;
   assign o_recv_cnt   = r_recv_cnt;
   assign o_lat_sum    = r_lat_sum;
   assign o_lat_max    = r_lat_max;
   assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pe_traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_traffic_gen
//  Brief    : Directed self-checking bench for pe_traffic_gen (nodes 5 and 15).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_traffic_gen;

   logic        clk;
   logic        rst;
   logic        i_enable;
   logic [2:0]  i_pattern;
   logic [8:0]  i_rate;
   logic [15:0] i_pkt_limit;
   logic [35:0] i_data;
   logic        i_data_valid;
   logic        i_data_ready;

   logic        o_data_ready;
   logic [35:0] o_data;
   logic        o_data_valid;
   logic [15:0] o_sent_cnt;
   logic [15:0] o_recv_cnt;
   logic [47:0] o_lat_sum;
   logic [31:0] o_lat_max;
   logic        o_done;

   logic        b_data_ready;
   logic [35:0] b_data;
   logic        b_data_valid;
   logic [15:0] b_sent_cnt;
   logic [15:0] b_recv_cnt;
   logic [47:0] b_lat_sum;
   logic [31:0] b_lat_max;
   logic        b_done;

   logic [31:0] tb_ts;
   int          checks = 0;
   int          errors = 0;

   pe_traffic_gen #(.Address(5)) dut (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_pattern(i_pattern),
      .i_rate(i_rate), .i_pkt_limit(i_pkt_limit), .i_data(i_data),
      .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
      .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
      .o_sent_cnt(o_sent_cnt), .o_recv_cnt(o_recv_cnt), .o_lat_sum(o_lat_sum),
      .o_lat_max(o_lat_max), .o_done(o_done)
   );

   pe_traffic_gen #(.Address(15)) dut15 (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_pattern(i_pattern),
      .i_rate(i_rate), .i_pkt_limit(i_pkt_limit), .i_data(i_data),
      .i_data_valid(i_data_valid), .o_data_ready(b_data_ready),
      .o_data(b_data), .o_data_valid(b_data_valid), .i_data_ready(i_data_ready),
      .o_sent_cnt(b_sent_cnt), .o_recv_cnt(b_recv_cnt), .o_lat_sum(b_lat_sum),
      .o_lat_max(b_lat_max), .o_done(b_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference timestamp: free-running cycle count since reset release
   always @(posedge clk or posedge rst) begin
      if (rst) tb_ts <= 32'd0;
      else     tb_ts <= tb_ts + 32'd1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (o_data_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (o_data_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout valid=%0b want 1 within 20 cycles", name, o_data_valid);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (o_data_valid !== 1'b0 || o_data !== 36'd0 || o_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs valid=%0b data=%h done=%0b want 0/0/0", o_data_valid, o_data, o_done);
      end
      checks++;
      if (o_sent_cnt !== 16'd0 || o_recv_cnt !== 16'd0 || o_lat_sum !== 48'd0 || o_lat_max !== 32'd0) begin
         errors++;
         $display("FAIL reset_stats sent=%0d recv=%0d sum=%0d max=%0d want all 0", o_sent_cnt, o_recv_cnt, o_lat_sum, o_lat_max);
      end
      checks++;
      if (o_data_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %0b want 1", o_data_ready);
      end
   endtask

   task automatic test_ts_wrap();
      int n;
      n = 0;
      while (tb_ts != 32'd3 && n < 10) begin
         tick();
         n++;
      end
      i_data       = {4'h2, 32'hFFFF_FFFE};
      i_data_valid = 1'b1;
      tick();
      i_data_valid = 1'b0;
      checks++;
      if (o_recv_cnt !== 16'd1 || o_lat_sum !== 48'd5 || o_lat_max !== 32'd5) begin
         errors++;
         $display("FAIL ts_wrap recv=%0d sum=%0d max=%0d want 1/5/5", o_recv_cnt, o_lat_sum, o_lat_max);
      end
   endtask

   task automatic test_complement_run();
      int          nvalid;
      logic        prev_valid;
      logic [31:0] prev_stamp;
      nvalid      = 0;
      prev_valid  = 1'b0;
      prev_stamp  = 32'd0;
      i_pattern   = 3'd1;
      i_rate      = 9'd256;
      i_pkt_limit = 16'd3;
      i_data_ready = 1'b1;
      i_enable    = 1'b1;
      tick();
      checks++;
      if (o_recv_cnt !== 16'd0 || o_lat_max !== 32'd0) begin
         errors++;
         $display("FAIL start_clear recv=%0d max=%0d want 0/0", o_recv_cnt, o_lat_max);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (o_data_valid === 1'b1) begin
            checks++;
            if (o_data[35:32] !== 4'd10 || o_data[31:0] !== tb_ts - 32'd1) begin
               errors++;
               $display("FAIL compl_flit data=%h want dest a stamp %h", o_data, tb_ts - 32'd1);
            end
            if (nvalid > 0) begin
               checks++;
               if (o_data[31:0] !== prev_stamp + 32'd2 || prev_valid) begin
                  errors++;
                  $display("FAIL compl_spacing stamp=%h prev=%h prev_valid=%0b want prev+2, gap", o_data[31:0], prev_stamp, prev_valid);
               end
            end
            prev_stamp = o_data[31:0];
            nvalid++;
         end
         prev_valid = o_data_valid;
      end
      checks++;
      if (nvalid != 3 || o_sent_cnt !== 16'd3 || o_done !== 1'b1) begin
         errors++;
         $display("FAIL compl_done flits=%0d sent=%0d done=%0b want 3/3/1", nvalid, o_sent_cnt, o_done);
      end
      i_enable = 1'b0;
      tick();
      tick();
      checks++;
      if (o_done !== 1'b1 || o_sent_cnt !== 16'd3 || o_data_valid !== 1'b0) begin
         errors++;
         $display("FAIL done_hold done=%0b sent=%0d valid=%0b want 1/3/0", o_done, o_sent_cnt, o_data_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [35:0] held;
      i_pkt_limit  = 16'd0;
      i_data_ready = 1'b0;
      i_enable     = 1'b1;
      tick();
      checks++;
      if (o_done !== 1'b0 || o_sent_cnt !== 16'd0) begin
         errors++;
         $display("FAIL restart_clear done=%0b sent=%0d want 0/0", o_done, o_sent_cnt);
      end
      wait_valid("bp");
      held = o_data;
      for (int i = 0; i < 7; i++) begin
         if (i == 3) i_enable = 1'b0;
         tick();
         checks++;
         if (o_data_valid !== 1'b1 || o_data !== held || o_sent_cnt !== 16'd0) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d valid=%0b data=%h sent=%0d want 1/%h/0", i, o_data_valid, o_data, o_sent_cnt, held);
         end
      end
      i_data_ready = 1'b1;
      tick();
      checks++;
      if (o_sent_cnt !== 16'd1 || o_data_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release sent=%0d valid=%0b want 1/0", o_sent_cnt, o_data_valid);
      end
      tick();
      tick();
      tick();
      checks++;
      if (o_sent_cnt !== 16'd1 || o_data_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_idle sent=%0d valid=%0b want 1/0", o_sent_cnt, o_data_valid);
      end
   endtask

   task automatic test_patterns();
      logic [2:0] pats [2];
      logic [3:0] exp5 [2];
      logic [3:0] exp15 [2];
      pats[0] = 3'd5; exp5[0] = 4'd13; exp15[0] = 4'd7;
      pats[1] = 3'd6; exp5[1] = 4'd6;  exp15[1] = 4'd0;
      i_rate       = 9'd256;
      i_pkt_limit  = 16'd1;
      i_data_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         i_pattern = pats[k];
         i_enable  = 1'b1;
         wait_valid("pattern");
         checks++;
         if (o_data[35:32] !== exp5[k] || b_data[35:32] !== exp15[k] || b_data_valid !== 1'b1) begin
            errors++;
            $display("FAIL pattern%0d dest5=%0d dest15=%0d v15=%0b want %0d/%0d/1", pats[k], o_data[35:32], b_data[35:32], b_data_valid, exp5[k], exp15[k]);
         end
         tick();
         i_enable = 1'b0;
         tick();
         tick();
      end
   endtask

   task automatic test_sink();
      checks++;
      if (o_recv_cnt !== 16'd0) begin
         errors++;
         $display("FAIL sink_pre recv=%0d want 0", o_recv_cnt);
      end
      i_data       = {4'h3, tb_ts - 32'd12};
      i_data_valid = 1'b1;
      tick();
      i_data       = {4'h9, tb_ts - 32'd4};
      tick();
      i_data_valid = 1'b0;
      checks++;
      if (o_recv_cnt !== 16'd2 || o_lat_sum !== 48'd16 || o_lat_max !== 32'd12) begin
         errors++;
         $display("FAIL sink_stats recv=%0d sum=%0d max=%0d want 2/16/12", o_recv_cnt, o_lat_sum, o_lat_max);
      end
   endtask

   task automatic test_clear_rate0();
      int nvalid;
      nvalid       = 0;
      i_rate       = 9'd0;
      i_pkt_limit  = 16'd0;
      i_data       = {4'h1, tb_ts - 32'd7};
      i_data_valid = 1'b1;
      i_enable     = 1'b1;
      tick();
      i_data_valid = 1'b0;
      checks++;
      if (o_recv_cnt !== 16'd1 || o_lat_sum !== 48'd7 || o_lat_max !== 32'd7) begin
         errors++;
         $display("FAIL clear_with_rx recv=%0d sum=%0d max=%0d want 1/7/7", o_recv_cnt, o_lat_sum, o_lat_max);
      end
      for (int i = 0; i < 200; i++) begin
         tick();
         if (o_data_valid === 1'b1) nvalid++;
      end
      checks++;
      if (nvalid != 0 || o_sent_cnt !== 16'd0) begin
         errors++;
         $display("FAIL rate0 valid_cycles=%0d sent=%0d want 0/0", nvalid, o_sent_cnt);
      end
      i_enable = 1'b0;
      tick();
   endtask

   task automatic test_rate64();
      int sent;
      int gen;
      i_rate       = 9'd64;
      i_pkt_limit  = 16'd0;
      i_data_ready = 1'b1;
      i_enable     = 1'b1;
      tick();
      for (int i = 0; i < 4096; i++) tick();
      sent = int'(o_sent_cnt) + (o_data_valid === 1'b1 ? 1 : 0);
      gen  = 4096 - sent;
      checks++;
      if (sent * 100 < gen * 22 || sent * 100 > gen * 28) begin
         errors++;
         $display("FAIL rate64 sent=%0d gen=%0d want ratio 22..28 percent", sent, gen);
      end
      i_enable = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset_in_wait();
      i_rate       = 9'd256;
      i_data_ready = 1'b0;
      i_enable     = 1'b1;
      i_data       = {4'h0, tb_ts - 32'd2};
      i_data_valid = 1'b1;
      tick();
      i_data_valid = 1'b0;
      wait_valid("rstwait");
      #2 rst = 1'b1;
      #1;
      checks++;
      if (o_data_valid !== 1'b0 || o_data !== 36'd0 || o_sent_cnt !== 16'd0 || o_recv_cnt !== 16'd0 || o_lat_sum !== 48'd0) begin
         errors++;
         $display("FAIL async_reset valid=%0b data=%h sent=%0d recv=%0d sum=%0d want all 0", o_data_valid, o_data, o_sent_cnt, o_recv_cnt, o_lat_sum);
      end
      i_enable = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (o_data_valid !== 1'b0 || o_done !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle valid=%0b done=%0b want 0/0", o_data_valid, o_done);
      end
   endtask

   initial begin
      rst          = 1'b1;
      i_enable     = 1'b0;
      i_pattern    = 3'd0;
      i_rate       = 9'd0;
      i_pkt_limit  = 16'd0;
      i_data       = 36'd0;
      i_data_valid = 1'b0;
      i_data_ready = 1'b0;
      #22;
      test_reset();
      tick();
      rst = 1'b0;
      test_ts_wrap();
      test_complement_run();
      test_backpressure();
      test_patterns();
      test_sink();
      test_clear_rate0();
      test_rate64();
      test_reset_in_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
